// File: rtl/ppu_quant_if.sv
// Streaming port bundle between the array controller (master) and the PPU
// requantiser (slave): int32 psum words in, packed uint8 ofmap words out.
interface ppu_quant_if #(
  parameter int LANES = 4,
  parameter int WORDS = 64
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic                  i_clear;
  logic                  i_en;
  logic [32*LANES-1:0]   i_data;
  logic [4:0]            i_shift;
  logic                  i_mode;
  logic                  o_valid;
  logic [8*LANES-1:0]    o_data;
  logic [AW-1:0]         o_addr;
  logic                  o_done;

  modport master (
    output i_clear, i_en, i_data, i_shift, i_mode,
    input  o_valid, o_data, o_addr, o_done
  );

  modport slave (
    input  i_clear, i_en, i_data, i_shift, i_mode,
    output o_valid, o_data, o_addr, o_done
  );
endinterface

// File: rtl/ppu_quant.sv
// Post-processing unit: ReLU, rounding right-shift requant, int8 saturation and
// optional 2:1 max-pool, three register stages, writing ofmap words to the GLB.
module ppu_quant #(
  parameter int LANES = 4,
  parameter int WORDS = 64
) (
  input  logic           clk,
  input  logic           rst,
  ppu_quant_if.slave     bus
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW = $clog2(WORDS + 1);

  logic [CW-1:0]               in_cnt;
  logic [CW-1:0]               out_cnt;
  logic [CW-1:0]               out_target;
  logic                        mode_q;
  logic                        accept;
  logic                        mode_now;

  logic                        s1_valid;
  logic                        s1_emit;
  logic                        s1_pair;
  logic [4:0]                  s1_shift;
  logic [LANES-1:0][30:0]      s1_data;

  logic                        s2_valid;
  logic                        s2_emit;
  logic                        s2_pair;
  logic [LANES-1:0][32:0]      s2_data;

  logic [LANES-1:0][30:0]      relu;
  logic [LANES-1:0][32:0]      rnd;
  logic [LANES-1:0][7:0]       sat;
  logic [LANES-1:0][7:0]       merged;
  logic [LANES-1:0][7:0]       pool;
  logic [LANES-1:0][7:0]       out_data;
  logic                        out_valid;
  logic [AW-1:0]               out_addr;
  logic                        done;

  assign accept     = bus.i_en && !bus.i_clear && (in_cnt < CW'(WORDS));
  // word 0 of a frame uses the live mode bit; the rest use the latched copy
  assign mode_now   = (in_cnt == '0) ? bus.i_mode : mode_q;
  assign out_target = mode_q ? CW'(WORDS / 2) : CW'(WORDS);

  always_comb begin
    relu   = '0;
    rnd    = '0;
    sat    = '0;
    merged = '0;
    for (int k = 0; k < LANES; k++) begin
      relu[k]   = bus.i_data[32*k+31] ? 31'd0 : bus.i_data[32*k +: 31];
      // 33-bit sum keeps the half-LSB rounding term from overflowing
      rnd[k]    = ({2'b00, s1_data[k]}
                   + ((s1_shift == 5'd0) ? 33'd0 : (33'd1 << (s1_shift - 5'd1))))
                  >> s1_shift;
      sat[k]    = (s2_data[k] > 33'd127) ? 8'd127 : s2_data[k][7:0];
      merged[k] = (s2_pair && (pool[k] > sat[k])) ? pool[k] : sat[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_emit  <= 1'b0;
      s1_pair  <= 1'b0;
      s1_shift <= '0;
      s1_data  <= '0;
      s2_emit  <= 1'b0;
      s2_pair  <= 1'b0;
      s2_data  <= '0;
    end else begin
      s1_emit  <= !mode_now || in_cnt[0];
      s1_pair  <= mode_now && in_cnt[0];
      s1_shift <= bus.i_shift;
      s1_data  <= relu;
      s2_emit  <= s1_emit;
      s2_pair  <= s1_pair;
      s2_data  <= rnd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      mode_q    <= 1'b0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      pool      <= '0;
      done      <= 1'b0;
    end else if (bus.i_clear) begin
      in_cnt    <= '0;
      out_cnt   <= '0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      done      <= 1'b0;
    end else begin
      if (accept) begin
        in_cnt <= in_cnt + CW'(1);
        if (in_cnt == '0) mode_q <= bus.i_mode;
      end
      s1_valid  <= accept;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid && s2_emit;
      if (s2_valid) begin
        if (s2_emit) out_data <= merged;
        else         pool     <= sat;
      end
      // address stops on the last word of the frame instead of wrapping
      if (out_valid) begin
        out_cnt <= out_cnt + CW'(1);
        if (out_cnt + CW'(1) == out_target) done     <= 1'b1;
        else                                out_addr <= out_addr + AW'(1);
      end
    end
  end

  assign bus.o_valid = out_valid;
  assign bus.o_data  = out_data;
  assign bus.o_addr  = out_addr;
  assign bus.o_done  = done;
endmodule

// File: tb/tb_ppu_quant.sv
// Directed bench for ppu_quant: ReLU/saturation, rounding, back-to-back frame,
// max-pool mode, i_clear abort and mid-frame reset.
module tb_ppu_quant;
  localparam int LANES = 4;
  localparam int WORDS = 64;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  ppu_quant_if #(.LANES(LANES), .WORDS(WORDS)) bus ();
  ppu_quant #(.LANES(LANES), .WORDS(WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [127:0] pack32(input int a0, input int a1, input int a2, input int a3);
    return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  function automatic logic [31:0] pack8(input int a0, input int a1, input int a2, input int a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic int q0(input int x);
    if (x < 0)   return 0;
    if (x > 127) return 127;
    return x;
  endfunction

  function automatic int pool_lane(input int w, input int k);
    int a[4];
    if (w == 0)      a = '{10, 200, -1, 7};
    else if (w == 1) a = '{20, 5, 3, 7};
    else             a = '{w, 130 - w, -w, w % 7};
    return a[k];
  endfunction

  task automatic idle_inputs();
    bus.i_clear = 1'b0;
    bus.i_en    = 1'b0;
    bus.i_data  = '0;
    bus.i_shift = '0;
    bus.i_mode  = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.i_clear = 1'b1;
    @(negedge clk);
    bus.i_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
    n_vec++; if (bus.o_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", bus.o_data); end
    n_vec++; if (bus.o_addr !== 6'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", bus.o_addr); end
    n_vec++; if (bus.o_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.o_done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_relu_sat();
    logic [31:0] exp_d;
    exp_d = pack8(0, 0, 127, 127);
    pulse_clear();
    bus.i_mode  = 1'b0;
    bus.i_shift = 5'd0;
    bus.i_data  = pack32(-5, 0, 127, 300);
    bus.i_en    = 1'b1;
    @(negedge clk);
    bus.i_en = 1'b0;
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL relu_lat1 got %b want 0", bus.o_valid); end
    @(negedge clk);
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL relu_lat2 got %b want 0", bus.o_valid); end
    @(negedge clk);
    n_vec++; if (bus.o_valid !== 1'b1) begin n_err++; $display("FAIL relu_valid got %b want 1", bus.o_valid); end
    n_vec++; if (bus.o_data !== exp_d) begin n_err++; $display("FAIL relu_data got %h want %h", bus.o_data, exp_d); end
    n_vec++; if (bus.o_addr !== 6'd0) begin n_err++; $display("FAIL relu_addr got %0d want 0", bus.o_addr); end
    @(negedge clk);
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL relu_pulse got %b want 0", bus.o_valid); end
    n_vec++; if (bus.o_data !== exp_d) begin n_err++; $display("FAIL relu_hold got %h want %h", bus.o_data, exp_d); end
    n_vec++; if (bus.o_addr !== 6'd1) begin n_err++; $display("FAIL relu_addr_inc got %0d want 1", bus.o_addr); end
  endtask

  task automatic test_rounding();
    int sh[3]   = '{4, 1, 31};
    int d[3][4] = '{'{40, 23, 24, 8}, '{3, 255, -100, 252},
                    '{1073741824, 1073741823, 2147483647, 5}};
    int e[3][4] = '{'{3, 1, 2, 1}, '{2, 127, 0, 126}, '{1, 0, 1, 0}};
    logic [31:0] exp_d;
    pulse_clear();
    bus.i_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_d       = pack8(e[i][0], e[i][1], e[i][2], e[i][3]);
      bus.i_shift = 5'(sh[i]);
      bus.i_data  = pack32(d[i][0], d[i][1], d[i][2], d[i][3]);
      bus.i_en    = 1'b1;
      @(negedge clk);
      bus.i_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_vec++; if (bus.o_valid !== 1'b1) begin n_err++; $display("FAIL round_valid[%0d] got %b want 1", i, bus.o_valid); end
      n_vec++; if (bus.o_data !== exp_d) begin n_err++; $display("FAIL round_data[%0d] got %h want %h", i, bus.o_data, exp_d); end
      n_vec++; if (bus.o_addr !== 6'(i)) begin n_err++; $display("FAIL round_addr[%0d] got %0d want %0d", i, bus.o_addr, i); end
    end
  endtask

  task automatic test_back_to_back();
    int          j;
    int          pulses;
    logic        exp_v;
    logic [5:0]  exp_a;
    logic [31:0] exp_d;
    pulses = 0;
    pulse_clear();
    bus.i_mode  = 1'b0;
    bus.i_shift = 5'd0;
    for (int t = 0; t < 70; t++) begin
      bus.i_en   = (t < 65);
      bus.i_data = pack32(t, t + 1, -t, 2 * t);
      @(negedge clk);
      j     = t - 2;
      exp_v = (j >= 0 && j < WORDS);
      exp_a = (t < 2) ? 6'd0 : ((j > 63) ? 6'd63 : 6'(j));
      exp_d = pack8(q0(j), q0(j + 1), q0(-j), q0(2 * j));
      if (bus.o_valid === 1'b1) pulses++;
      n_vec++; if (bus.o_valid !== exp_v) begin n_err++; $display("FAIL b2b_valid t=%0d got %b want %b", t, bus.o_valid, exp_v); end
      n_vec++; if (bus.o_addr !== exp_a) begin n_err++; $display("FAIL b2b_addr t=%0d got %0d want %0d", t, bus.o_addr, exp_a); end
      n_vec++; if (bus.o_done !== (t >= 66)) begin n_err++; $display("FAIL b2b_done t=%0d got %b want %b", t, bus.o_done, (t >= 66)); end
      if (exp_v) begin
        n_vec++; if (bus.o_data !== exp_d) begin n_err++; $display("FAIL b2b_data t=%0d got %h want %h", t, bus.o_data, exp_d); end
      end
    end
    bus.i_en = 1'b0;
    n_vec++; if (pulses != 64) begin n_err++; $display("FAIL b2b_pulses got %0d want 64", pulses); end
  endtask

  task automatic test_pool();
    int          j;
    int          p;
    int          pulses;
    int          ev[4];
    logic        exp_v;
    logic [5:0]  exp_a;
    logic [31:0] exp_d;
    pulses = 0;
    pulse_clear();
    bus.i_shift = 5'd0;
    for (int t = 0; t < 69; t++) begin
      bus.i_en   = (t < 64);
      bus.i_mode = (t == 0) ? 1'b1 : ((t % 3) != 0);
      bus.i_data = pack32(pool_lane(t, 0), pool_lane(t, 1), pool_lane(t, 2), pool_lane(t, 3));
      @(negedge clk);
      j     = t - 2;
      p     = j >> 1;
      exp_v = (j >= 0 && j < WORDS && (j % 2) == 1);
      exp_a = (t < 2) ? 6'd0 : ((j > 63) ? 6'd31 : 6'(p));
      for (int k = 0; k < 4; k++) begin
        ev[k] = (q0(pool_lane(2 * p, k)) > q0(pool_lane(2 * p + 1, k)))
                ? q0(pool_lane(2 * p, k)) : q0(pool_lane(2 * p + 1, k));
      end
      exp_d = (p == 0) ? pack8(20, 127, 3, 7) : pack8(ev[0], ev[1], ev[2], ev[3]);
      if (bus.o_valid === 1'b1) pulses++;
      n_vec++; if (bus.o_valid !== exp_v) begin n_err++; $display("FAIL pool_valid t=%0d got %b want %b", t, bus.o_valid, exp_v); end
      n_vec++; if (bus.o_addr !== exp_a) begin n_err++; $display("FAIL pool_addr t=%0d got %0d want %0d", t, bus.o_addr, exp_a); end
      n_vec++; if (bus.o_done !== (t >= 66)) begin n_err++; $display("FAIL pool_done t=%0d got %b want %b", t, bus.o_done, (t >= 66)); end
      if (exp_v) begin
        n_vec++; if (bus.o_data !== exp_d) begin n_err++; $display("FAIL pool_data t=%0d got %h want %h", t, bus.o_data, exp_d); end
      end
    end
    bus.i_en = 1'b0;
    n_vec++; if (pulses != 32) begin n_err++; $display("FAIL pool_pulses got %0d want 32", pulses); end
  endtask

  task automatic test_clear();
    logic [31:0] exp_d;
    exp_d = pack8(11, 22, 0, 127);
    n_vec++; if (bus.o_done !== 1'b1) begin n_err++; $display("FAIL clr_pre_done got %b want 1", bus.o_done); end
    pulse_clear();
    n_vec++; if (bus.o_done !== 1'b0) begin n_err++; $display("FAIL clr_done_drop got %b want 0", bus.o_done); end
    bus.i_mode  = 1'b0;
    bus.i_shift = 5'd0;
    bus.i_en    = 1'b1;
    bus.i_data  = pack32(1, 2, 3, 4);
    @(negedge clk);
    bus.i_data  = pack32(5, 6, 7, 8);
    @(negedge clk);
    bus.i_clear = 1'b1;
    bus.i_data  = pack32(9, 9, 9, 9);
    @(negedge clk);
    bus.i_clear = 1'b0;
    bus.i_en    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL clr_quiet[%0d] got %b want 0", i, bus.o_valid); end
      @(negedge clk);
    end
    n_vec++; if (bus.o_addr !== 6'd0) begin n_err++; $display("FAIL clr_addr got %0d want 0", bus.o_addr); end
    n_vec++; if (bus.o_done !== 1'b0) begin n_err++; $display("FAIL clr_done got %b want 0", bus.o_done); end
    bus.i_data = pack32(11, 22, -33, 444);
    bus.i_en   = 1'b1;
    @(negedge clk);
    bus.i_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (bus.o_valid !== 1'b1) begin n_err++; $display("FAIL clr_next_valid got %b want 1", bus.o_valid); end
    n_vec++; if (bus.o_addr !== 6'd0) begin n_err++; $display("FAIL clr_next_addr got %0d want 0", bus.o_addr); end
    n_vec++; if (bus.o_data !== exp_d) begin n_err++; $display("FAIL clr_next_data got %h want %h", bus.o_data, exp_d); end
  endtask

  task automatic test_rst_mid();
    logic [31:0] exp_d;
    exp_d = pack8(4, 3, 3, 4);
    pulse_clear();
    bus.i_mode  = 1'b1;
    bus.i_shift = 5'd0;
    bus.i_data  = pack32(50, 60, 70, 80);
    bus.i_en    = 1'b1;
    @(negedge clk);
    bus.i_en = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL rst_even_novalid got %b want 0", bus.o_valid); end
    bus.i_data = pack32(1, 1, 1, 1);
    bus.i_en   = 1'b1;
    @(negedge clk);
    rst         = 1'b1;
    bus.i_clear = 1'b1;
    bus.i_data  = pack32(99, 99, 99, 99);
    @(negedge clk);
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", bus.o_valid); end
    n_vec++; if (bus.o_data !== 32'h0) begin n_err++; $display("FAIL rst_data got %h want 0", bus.o_data); end
    n_vec++; if (bus.o_addr !== 6'd0) begin n_err++; $display("FAIL rst_addr got %0d want 0", bus.o_addr); end
    n_vec++; if (bus.o_done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", bus.o_done); end
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL rst_quiet[%0d] got %b want 0", i, bus.o_valid); end
    end
    bus.i_mode = 1'b1;
    bus.i_en   = 1'b1;
    bus.i_data = pack32(1, 2, 3, 4);
    @(negedge clk);
    bus.i_data = pack32(4, 3, 2, 1);
    @(negedge clk);
    bus.i_en = 1'b0;
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL rst_pair_early got %b want 0", bus.o_valid); end
    @(negedge clk);
    n_vec++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL rst_pair_even got %b want 0", bus.o_valid); end
    @(negedge clk);
    n_vec++; if (bus.o_valid !== 1'b1) begin n_err++; $display("FAIL rst_pair_valid got %b want 1", bus.o_valid); end
    n_vec++; if (bus.o_data !== exp_d) begin n_err++; $display("FAIL rst_pair_data got %h want %h", bus.o_data, exp_d); end
    n_vec++; if (bus.o_addr !== 6'd0) begin n_err++; $display("FAIL rst_pair_addr got %0d want 0", bus.o_addr); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_relu_sat();
    test_rounding();
    test_back_to_back();
    test_pool();
    test_clear();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ppu_quant.md
PPU_QUANT -- requirements
Module: ppu_quant

Interface
REQ-001 SHALL have parameter LANES, default 4, number of int32 psum lanes per word.
REQ-002 SHALL have parameter WORDS, default 64, input words per frame.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_clear  input  1  frame start; clears counters, pipeline valids, done.
REQ-006 SHALL have port i_en  input  1  i_data valid this cycle (driven from controller i_en_ppu).
REQ-007 SHALL have port i_data  input  32*LANES  signed int32 psums, lane k at [32k+31:32k].
REQ-008 SHALL have port i_shift  input  5  requant right-shift amount, sampled with each i_en.
REQ-009 SHALL have port i_mode  input  1  0 = pass-through, 1 = 2:1 max-pool of consecutive words.
REQ-010 SHALL have port o_valid  output  1  o_data/o_addr valid this cycle.
REQ-011 SHALL have port o_data  output  8*LANES  unsigned int8 results, lane k at [8k+7:8k].
REQ-012 SHALL have port o_addr  output  clog2(WORDS)  GLB ofmap write address of o_data.
REQ-013 SHALL have port o_done  output  1  level-high after final output word of frame.

Function
REQ-014 SHALL accept an input word when i_en=1, i_clear=0 and input count < WORDS; other i_en cycles SHALL be ignored.
REQ-015 SHALL latch i_mode on the accepted word with input count 0; i_mode changes mid-frame SHALL be ignored.
REQ-016 SHALL have no backpressure; pipeline advances every cycle; i_en gaps of any length allowed.
REQ-017 Stage 1 (register): ReLU per lane, negative -> 0; i_shift registered alongside.
REQ-018 Stage 2 (register): per lane y = (x + 2^(s-1)) >> s for s>0, y = x for s=0; add done in 33 bits, no overflow.
REQ-019 Stage 3 (register): saturate per lane, y>127 -> 127, else y[7:0]; pack lanes.
REQ-020 Mode 0: o_valid SHALL assert exactly 3 cycles after accepting cycle; o_addr = accepted word index.
REQ-021 Mode 1: even-index word result SHALL be held in pool register, no o_valid; odd-index word SHALL produce per-lane unsigned max of pair, o_valid 3 cycles after odd word accepted, o_addr = index>>1.
REQ-022 o_addr SHALL increment by 1 after each o_valid, starting at 0 per frame; no wrap within a frame.
REQ-023 o_done SHALL rise the cycle after the last o_valid (WORDS outputs mode 0, WORDS/2 mode 1) and hold until i_clear or rst.
REQ-024 i_clear SHALL have priority over i_en in the same cycle; that word is dropped and in-flight pipeline words SHALL be discarded (valids cleared).
REQ-025 Input words accepted after count reaches WORDS SHALL produce no output and not alter o_addr or o_done.
REQ-026 o_data SHALL hold last value when o_valid=0.

Reset
REQ-027 On rst: o_valid=0, o_data=0, o_addr=0, o_done=0, all counters, pipeline valids, pool register and latched mode = 0.
REQ-028 rst mid-frame SHALL abort the frame; no output emitted for words accepted before rst.
REQ-029 rst SHALL take priority over i_clear and i_en.

Verification
REQ-030 Mode 0, shift 0, lanes {-5, 0, 127, 300} on one word -> 3 cycles later o_valid=1, o_data lanes {0,0,127,127}, o_addr=0.
REQ-031 Mode 0, shift 4, lane value 40 -> (40+8)>>4 = 3; value 23 -> 1; value 24 -> 2 (round half up).
REQ-032 Mode 0, 64 back-to-back words -> 64 o_valid pulses, o_addr 0..63 consecutive, o_done=1 cycle after last; 65th word ignored.
REQ-033 Mode 1, pair lanes {10,200,-1,7} then {20,5,3,7}, shift 0 -> single output {20,127,3,7}, o_addr=0; 64 words -> 32 outputs, o_done.
REQ-034 i_clear asserted with i_en while 2 words in flight -> no o_valid follows, o_addr=0, o_done=0, next accepted word is index 0.
REQ-035 rst asserted mid-frame in mode 1 with pool holding an even word -> all outputs 0 next cycle; new frame restarts at o_addr 0.
